// File: rtl/sram_fifo_pkg.sv
// Shared defaults for the SRAM-backed FIFO.
package sram_fifo_pkg;
    localparam int FIFO_WIDTH_DEF = 32;
    localparam int FIFO_SIZE_DEF  = 8;
endpackage

// File: rtl/sram1w1r.sv
// One-write one-read SRAM with registered read data.
// A same-address write/read pair returns the new write data.
module sram1w1r #(
    parameter int SETS_NUM   = 8,
    parameter int DATA_WIDTH = 32,
    localparam int AW = $clog2(SETS_NUM)
) (
    input  logic                  clk,
    input  logic                  read_en,
    input  logic [AW-1:0]         read_addr,
    output logic [DATA_WIDTH-1:0] read_data,
    input  logic                  write_en,
    input  logic [AW-1:0]         write_addr,
    input  logic [DATA_WIDTH-1:0] write_data
);
    logic [DATA_WIDTH-1:0] mem [SETS_NUM];

    always_ff @(posedge clk) begin
        if (write_en)
            mem[write_addr] <= write_data;
        if (read_en)
            read_data <= (write_en && write_addr == read_addr)
                ? write_data : mem[read_addr];
    end
endmodule

// File: rtl/sram_fifo.sv
// Show-ahead FIFO over a 1w1r SRAM; the head entry is held in the
// SRAM read register so dequeues stream without bubbles.
module sram_fifo
    import sram_fifo_pkg::*;
#(
    parameter int WIDTH                  = FIFO_WIDTH_DEF,
    parameter int SIZE                   = FIFO_SIZE_DEF,
    parameter int ALMOST_FULL_THRESHOLD  = SIZE,
    parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             enqueue_en,
    input  logic [WIDTH-1:0] enqueue_value,
    output logic             full,
    output logic             almost_full,
    input  logic             dequeue_en,
    output logic [WIDTH-1:0] dequeue_value,
    output logic             empty,
    output logic             almost_empty
);
    localparam int AW = $clog2(SIZE);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] sram_count;
    logic [CW-1:0] count;
    logic [CW-1:0] avail;
    logic          head_valid;
    logic          push;
    logic          pop;
    logic          read_issue;

    assign count        = sram_count + CW'(head_valid);
    assign full         = count == CW'(SIZE);
    assign empty        = count == '0;
    assign almost_full  = 32'(count) >= ALMOST_FULL_THRESHOLD;
    assign almost_empty = 32'(count) <= ALMOST_EMPTY_THRESHOLD;

    assign push = enqueue_en & ~full;
    assign pop  = dequeue_en & ~empty;

    // Refill the head register whenever it is free or being consumed.
    assign avail      = sram_count + CW'(push);
    assign read_issue = (avail != '0) && (!head_valid || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            sram_count <= '0;
            head_valid <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            sram_count <= '0;
            head_valid <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (read_issue)
                rd_ptr <= rd_ptr + 1'b1;
            sram_count <= avail - CW'(read_issue);
            if (read_issue)
                head_valid <= 1'b1;
            else if (pop)
                head_valid <= 1'b0;
        end
    end

    sram1w1r #(
        .SETS_NUM   (SIZE),
        .DATA_WIDTH (WIDTH)
    ) u_sram (
        .clk        (clk),
        .read_en    (read_issue & ~flush),
        .read_addr  (rd_ptr),
        .read_data  (dequeue_value),
        .write_en   (push & ~flush),
        .write_addr (wr_ptr),
        .write_data (enqueue_value)
    );

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(enqueue_en && full))
                else $warning("sram_fifo: enqueue while full dropped");
            assert (!(dequeue_en && empty))
                else $warning("sram_fifo: dequeue while empty dropped");
        end
    end
`endif
endmodule
